nibble_serial_sub: RTL and testbench

NIBBLE_SERIAL_SUB -- requirements
Module: nibble_serial_sub

---
 rtl/nibble_serial_sub_if.sv | 28 ++
 rtl/nibble_serial_sub.sv | 89 ++++++++
 tb/tb_nibble_serial_sub.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_sub_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// The master side supplies the operands and the slave side returns the difference.
interface nibble_serial_sub_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero
    );
endinterface

// File: rtl/nibble_serial_sub.sv
// Nibble-serial subtractor: computes (a - b - bin) one 4-bit digit per cycle, LSB first.
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | rippling one nibble per cycle through the 4-bit subtract stage
// DONE  | result held on diff/bout/zero until out_ready
module nibble_serial_sub #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_sub_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_d;
    logic [W-1:0]  a_q, b_q, diff_q;
    logic          brw, bout_q;
    logic [IW-1:0] idx;
    logic [3:0]    a_nib, b_nib, d_nib;
    logic          c, brw_n, last;

    assign a_nib = a_q[int'(idx) * 4 +: 4];
    assign b_nib = b_q[int'(idx) * 4 +: 4];
    assign last  = (idx == IW'(NIBBLES - 1));

    // single 4-bit full-subtract stage, borrow rippled bit by bit
    always_comb begin
        d_nib = '0;
        c     = brw;
        for (int i = 0; i < 4; i++) begin
            d_nib[i] = a_nib[i] ^ b_nib[i] ^ c;
            c        = (~a_nib[i] & b_nib[i]) | (~(a_nib[i] ^ b_nib[i]) & c);
        end
        brw_n = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_d = BUSY;
            BUSY:    if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            brw    <= 1'b0;
            bout_q <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
                        brw <= bus.bin;
                        idx <= '0;
                    end
                end
                BUSY: begin
                    diff_q[int'(idx) * 4 +: 4] <= d_nib;
                    brw <= brw_n;
                    idx <= idx + 1'b1;
                    if (last) bout_q <= brw_n;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = (state == DONE) && (diff_q == '0);
endmodule

// File: tb/tb_nibble_serial_sub.sv
// Scoreboard bench for nibble_serial_sub with NIBBLES=4.
module tb_nibble_serial_sub;
    logic clk = 1'b0;
    logic rst_n;

    nibble_serial_sub_if #(.NIBBLES(4)) bus ();

    nibble_serial_sub #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        bo;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
        logic [16:0] r;
        exp_t e;
        r    = {1'b0, ta} - {1'b0, tb_} - {16'd0, tbin};
        e.d  = r[15:0];
        e.bo = r[16];
        return e;
    endfunction

    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                            input bit push);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_;
        bus.bin      = tbin;
        chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        if (push) sb.push_back(model(ta, tb_, tbin));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // called 1ns after the accept edge; out_valid must rise after exactly 4 more edges
    task automatic wait_result();
        int   cycles;
        exp_t e;
        cycles = 0;
        while (!bus.out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("latency", 32'(cycles), 32'd4);
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("diff", 32'(bus.diff), 32'(e.d));
                chk("bout", 32'(bus.bout), 32'(e.bo));
                chk("zero", 32'(bus.zero), 32'(e.d == 16'd0));
            end
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("out_valid_after_release", 32'(bus.out_valid), 32'd0);
        chk("in_ready_after_release", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
        start_op(ta, tb_, tbin, 1'b1);
        wait_result();
        release_out();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held_d;
        logic        held_b;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_bout", 32'(bus.bout), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases: plain, full ripple, zero result, borrow-in only
        do_op(16'h1234, 16'h0234, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0);
        do_op(16'h0005, 16'h0005, 1'b0);
        do_op(16'h0000, 16'h0000, 1'b1);

        // hold DONE with out_ready low while new operands are offered
        start_op(16'h00FF, 16'h0F00, 1'b1, 1'b1);
        wait_result();
        held_d = model(16'h00FF, 16'h0F00, 1'b1).d;
        held_b = model(16'h00FF, 16'h0F00, 1'b1).bo;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a        = 16'hAAAA;
            bus.b        = 16'h5555;
            bus.bin      = 1'b0;
            @(posedge clk);
            #1;
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_diff", 32'(bus.diff), 32'(held_d));
            chk("hold_bout", 32'(bus.bout), 32'(held_b));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("hold_release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("hold_release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("hold_release_diff_kept", 32'(bus.diff), 32'(held_d));
        sb.push_back(model(16'hAAAA, 16'h5555, 1'b0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_result();
        release_out();

        // reset mid-BUSY at idx=2: outputs clear without a clock edge, no result emerges
        start_op(16'h1234, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_diff", 32'(bus.diff), 32'd0);
        chk("midrst_bout", 32'(bus.bout), 32'd0);
        chk("midrst_zero", 32'(bus.zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_pulse", 32'(bus.out_valid), 32'd0);
        end
        do_op(16'h8000, 16'h7FFF, 1'b0);

        // exhaustive low nibble sweep
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int z = 0; z < 2; z++)
                    do_op(16'(x), 16'(y), z[0]);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
